simt_ctrl_unit: RTL and testbench

SIMT_CTRL_UNIT -- requirements
Module: simt_ctrl_unit

---
 rtl/simt_ctrl_unit_if.sv | 38 +++
 rtl/simt_ctrl_unit.sv | 206 ++++++++++++++++++++
 tb/tb_simt_ctrl_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simt_ctrl_unit_if.sv
// Control/status bundle between the SIMT warp sequencer and the datapath.
// The controller sits on the slave side; the issuing agent uses the master side.
interface simt_ctrl_unit_if #(
  parameter int OPW    = 4,
  parameter int ALUC_W = 4
);
  logic [OPW-1:0]    opcode;
  logic [1:0]        cmp_mode;
  logic              instr_valid;
  logic              MReady;
  logic              all_mask_true;
  logic              all_mask_false;
  logic              incPC;
  logic              loadFromI;
  logic [1:0]        s2;
  logic [ALUC_W-1:0] aluc;
  logic              reg_we;
  logic              MRead;
  logic              MWrite;
  logic              pstack_push;
  logic              pstack_pop;
  logic              pstack_complement;
  logic              busy;
  logic              halted;
  logic [1:0]        err_code;

  modport slave (
    input  opcode, cmp_mode, instr_valid, MReady, all_mask_true, all_mask_false,
    output incPC, loadFromI, s2, aluc, reg_we, MRead, MWrite,
           pstack_push, pstack_pop, pstack_complement, busy, halted, err_code
  );

  modport master (
    output opcode, cmp_mode, instr_valid, MReady, all_mask_true, all_mask_false,
    input  incPC, loadFromI, s2, aluc, reg_we, MRead, MWrite,
           pstack_push, pstack_pop, pstack_complement, busy, halted, err_code
  );
endinterface

// File: rtl/simt_ctrl_unit.sv
// SIMT warp control FSM: decodes one instruction at a time, sequences memory
// waits, tracks predicate-stack depth and latches sticky halt/error conditions.
module simt_ctrl_unit #(
  parameter int OPW          = 4,
  parameter int ALUC_W       = 4,
  parameter int PSTACK_DEPTH = 8,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic             clk,
  input logic             reset,
  simt_ctrl_unit_if.slave bus
);
  localparam int DW = $clog2(PSTACK_DEPTH + 1);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] ST_DECODE = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_LOADI  = 4'd1;
  localparam logic [3:0] OP_LOADC  = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_CLEAR  = 4'd4;
  localparam logic [3:0] OP_INC    = 4'd5;
  localparam logic [3:0] OP_ADD    = 4'd6;
  localparam logic [3:0] OP_MUL    = 4'd7;
  localparam logic [3:0] OP_MAD    = 4'd8;
  localparam logic [3:0] OP_SETP   = 4'd9;
  localparam logic [3:0] OP_IFP    = 4'd10;
  localparam logic [3:0] OP_ELSEP  = 4'd11;
  localparam logic [3:0] OP_WHILEP = 4'd12;
  localparam logic [3:0] OP_ENDIF  = 4'd13;
  localparam logic [3:0] OP_NOP    = 4'd14;
  localparam logic [3:0] OP_HALT   = 4'd15;

  logic [2:0]        state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        cmp_q, cmp_d;

  logic              inc_s, lfi_s, we_s, mrd_s, mwr_s;
  logic              push_s, pop_s, comp_s;
  logic [1:0]        s2_s;
  logic [ALUC_W-1:0] aluc_s;
  logic [31:0]       opc_wide_s;

  // Zero-extend so the illegal-opcode test stays meaningful for any OPW.
  assign opc_wide_s = 32'(bus.opcode);

  // Next-state and combinational control outputs.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    wait_d  = wait_q;
    err_d   = err_q;
    op_d    = op_q;
    cmp_d   = cmp_q;
    inc_s   = 1'b0;
    lfi_s   = 1'b0;
    s2_s    = 2'd0;
    aluc_s  = '0;
    we_s    = 1'b0;
    mrd_s   = 1'b0;
    mwr_s   = 1'b0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    comp_s  = 1'b0;
    case (state_q)
      ST_DECODE: begin
        if (bus.instr_valid) begin
          op_d  = bus.opcode[3:0];
          cmp_d = bus.cmp_mode;
          if (opc_wide_s > 32'd15) begin
            state_d = ST_ERR;
            err_d   = 2'd1;
          end else if (bus.opcode[3:0] == OP_LOAD || bus.opcode[3:0] == OP_STORE) begin
            state_d = ST_MEM;
            wait_d  = '0;
          end else if (bus.opcode[3:0] == OP_HALT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_EXEC: begin
        state_d = ST_DECODE;
        case (op_q)
          OP_LOADI:  begin s2_s = 2'd1; we_s = 1'b1; inc_s = 1'b1; end
          OP_LOADC:  begin s2_s = 2'd3; we_s = 1'b1; inc_s = 1'b1; end
          OP_CLEAR:  begin aluc_s = ALUC_W'(4'd4); we_s = 1'b1; inc_s = 1'b1; end
          OP_INC:    begin aluc_s = ALUC_W'(4'd3); we_s = 1'b1; inc_s = 1'b1; end
          OP_ADD:    begin aluc_s = ALUC_W'(4'd0); we_s = 1'b1; inc_s = 1'b1; end
          OP_MUL:    begin aluc_s = ALUC_W'(4'd1); we_s = 1'b1; inc_s = 1'b1; end
          OP_MAD:    begin aluc_s = ALUC_W'(4'd2); we_s = 1'b1; inc_s = 1'b1; end
          OP_SETP:   begin aluc_s = ALUC_W'({2'b10, cmp_q}); inc_s = 1'b1; end
          OP_IFP: begin
            push_s = 1'b1;
            if (bus.all_mask_false) lfi_s = 1'b1;
            else                    inc_s = 1'b1;
          end
          OP_ELSEP: begin
            comp_s = 1'b1;
            if (bus.all_mask_true) lfi_s = 1'b1;
            else                   inc_s = 1'b1;
          end
          OP_WHILEP: begin
            if (bus.all_mask_false) begin
              pop_s = 1'b1;
              inc_s = 1'b1;
            end else begin
              lfi_s = 1'b1;
            end
          end
          OP_ENDIF:  begin pop_s = 1'b1; inc_s = 1'b1; end
          OP_NOP:    begin inc_s = 1'b1; end
          default:   begin inc_s = 1'b0; end
        endcase
        // Stack over/underflow: the strobe never reaches the stack, the PC strobes still do.
        if ((push_s && depth_q == DW'(PSTACK_DEPTH)) ||
            ((pop_s || comp_s) && depth_q == '0)) begin
          push_s  = 1'b0;
          pop_s   = 1'b0;
          comp_s  = 1'b0;
          state_d = ST_ERR;
          err_d   = 2'd2;
        end else begin
          depth_d = depth_q + DW'(push_s) - DW'(pop_s);
        end
      end
      ST_MEM: begin
        mrd_s = (op_q == OP_LOAD);
        mwr_s = (op_q != OP_LOAD);
        if (bus.MReady) begin
          if (op_q == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            inc_s   = 1'b1;
            state_d = ST_DECODE;
          end
        end else if (wait_q == CW'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
          err_d   = 2'd3;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_WB: begin
        s2_s    = 2'd2;
        we_s    = 1'b1;
        inc_s   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_DECODE;
      depth_q <= '0;
      wait_q  <= '0;
      err_q   <= 2'd0;
      op_q    <= 4'd0;
      cmp_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      op_q    <= op_d;
      cmp_q   <= cmp_d;
    end
  end

  assign bus.incPC             = inc_s;
  assign bus.loadFromI         = lfi_s;
  assign bus.s2                = s2_s;
  assign bus.aluc              = aluc_s;
  assign bus.reg_we            = we_s;
  assign bus.MRead             = mrd_s;
  assign bus.MWrite            = mwr_s;
  assign bus.pstack_push       = push_s;
  assign bus.pstack_pop        = pop_s;
  assign bus.pstack_complement = comp_s;
  assign bus.busy              = (state_q != ST_DECODE);
  assign bus.halted            = (state_q == ST_HALT);
  assign bus.err_code          = err_q;
endmodule

// File: tb/tb_simt_ctrl_unit.sv
// Scoreboard bench for simt_ctrl_unit: a transaction-level model expands each
// issued instruction into its expected per-cycle output vectors.
module tb_simt_ctrl_unit;
  localparam int OPW    = 5;
  localparam int ALUC_W = 4;
  localparam int DEPTH  = 8;
  localparam int TMO    = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simt_ctrl_unit_if #(.OPW(OPW), .ALUC_W(ALUC_W)) bus();

  simt_ctrl_unit #(.OPW(OPW), .ALUC_W(ALUC_W), .PSTACK_DEPTH(DEPTH), .MEM_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Model: stack depth and sticky mode (0 running, 1 halted, 2 error with ecode).
  int          depth = 0;
  int          mode  = 0;
  logic [1:0]  ecode = 2'd0;

  // Vector layout: inc lfi s2[2] aluc[4] we mr mw push pop comp busy halted err[2]
  function automatic logic [17:0] mk(input logic inc, lfi, input logic [1:0] s2,
                                     input logic [3:0] alu, input logic we, mr, mw,
                                     input logic pu, po, co, bsy, hlt, input logic [1:0] err);
    return {inc, lfi, s2, alu, we, mr, mw, pu, po, co, bsy, hlt, err};
  endfunction

  function automatic logic [17:0] actual();
    return {bus.incPC, bus.loadFromI, bus.s2, bus.aluc, bus.reg_we, bus.MRead, bus.MWrite,
            bus.pstack_push, bus.pstack_pop, bus.pstack_complement, bus.busy, bus.halted,
            bus.err_code};
  endfunction

  function automatic logic [17:0] idle_exp();
    if (mode == 1)      return mk(0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 1, 2'd0);
    else if (mode == 2) return mk(0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, ecode);
    else                return mk(0, 0, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
  endfunction

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    logic [17:0] e;
    string       t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (actual() !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got %b want %b (inc,lfi,s2,aluc,we,mr,mw,pu,po,co,busy,halt,err)",
                   t, $time, actual(), e);
        end
      end
    end
  end

  task automatic step(input logic [17:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.instr_valid    = 1'b0;
    bus.opcode         = OPW'($urandom);
    bus.cmp_mode       = 2'($urandom);
    bus.MReady         = 1'($urandom);
    bus.all_mask_true  = 1'($urandom);
    bus.all_mask_false = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      step(idle_exp(), "idle");
    end
  endtask

  task automatic do_reset();
    rand_inputs();
    bus.instr_valid = 1'($urandom);
    reset = 1'b0;
    step(idle_exp(), "reset_cycle");
    reset = 1'b1;
    depth = 0;
    mode  = 0;
    ecode = 2'd0;
  endtask

  // Issue one instruction and predict every cycle it occupies.
  task automatic issue(input int op, input int cmp, input bit mt, input bit mf,
                       input int d, input int rst_at);
    logic inc, lfi, we, pu, po, co;
    logic [1:0] s2;
    logic [3:0] alu;
    rand_inputs();
    bus.instr_valid    = 1'b1;
    bus.opcode         = OPW'(op);
    bus.cmp_mode       = 2'(cmp);
    bus.all_mask_true  = mt;
    bus.all_mask_false = mf;
    if (mode != 0) begin
      step(idle_exp(), "sticky_ignores_issue");
      return;
    end
    step(idle_exp(), $sformatf("decode_op%0d", op));
    bus.instr_valid = 1'b0;
    bus.opcode      = OPW'($urandom);
    bus.cmp_mode    = 2'($urandom);
    if (op > 15) begin
      mode = 2; ecode = 2'd1;
      return;
    end
    if (op == 15) begin
      mode = 1;
      return;
    end
    if (op == 0 || op == 3) begin
      for (int i = 0; i <= TMO; i++) begin
        bus.MReady = (i == d);
        if (i == rst_at) begin
          bus.MReady = 1'b0;
          reset = 1'b0;
          step(mk(0, 0, 2'd0, 4'd0, 0, op == 0, op == 3, 0, 0, 0, 1, 0, 2'd0), "mem_reset");
          reset = 1'b1;
          depth = 0; mode = 0; ecode = 2'd0;
          return;
        end
        step(mk((op == 3) && (i == d), 0, 2'd0, 4'd0, 0, op == 0, op == 3, 0, 0, 0, 1, 0, 2'd0),
             $sformatf("mem_op%0d_w%0d", op, i));
        if (i == d) begin
          if (op == 0) begin
            bus.MReady = 1'($urandom);
            step(mk(1, 0, 2'd2, 4'd0, 1, 0, 0, 0, 0, 0, 1, 0, 2'd0), "load_wb");
          end
          return;
        end
      end
      mode = 2; ecode = 2'd3;
      return;
    end
    inc = 0; lfi = 0; we = 0; pu = 0; po = 0; co = 0; s2 = 2'd0; alu = 4'd0;
    case (op)
      1:  begin s2 = 2'd1; we = 1; inc = 1; end
      2:  begin s2 = 2'd3; we = 1; inc = 1; end
      4:  begin alu = 4'd4; we = 1; inc = 1; end
      5:  begin alu = 4'd3; we = 1; inc = 1; end
      6:  begin alu = 4'd0; we = 1; inc = 1; end
      7:  begin alu = 4'd1; we = 1; inc = 1; end
      8:  begin alu = 4'd2; we = 1; inc = 1; end
      9:  begin alu = 4'(8 + cmp); inc = 1; end
      10: begin pu = 1; lfi = mf; inc = !mf; end
      11: begin co = 1; lfi = mt; inc = !mt; end
      12: begin po = mf; inc = mf; lfi = !mf; end
      13: begin po = 1; inc = 1; end
      default: begin inc = 1; end
    endcase
    if ((pu && depth == DEPTH) || ((po || co) && depth == 0)) begin
      pu = 0; po = 0; co = 0;
      mode = 2; ecode = 2'd2;
    end else begin
      depth = depth + int'(pu) - int'(po);
    end
    step(mk(inc, lfi, s2, alu, we, 0, 0, pu, po, co, 1, 0, 2'd0), $sformatf("exec_op%0d", op));
  endtask

  initial begin
    int r, op, d, ra;
    rand_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(idle_exp(), "reset_state");
    reset = 1'b1;
    idle(2);

    issue(1, 0, 0, 0, 0, -1);          // LOADI
    idle(1);
    issue(0, 0, 0, 0, 3, -1);          // LOAD, 3 wait cycles
    issue(2, 0, 0, 0, 0, -1);          // LOADC
    issue(9, 2, 0, 0, 0, -1);          // SETP GT -> aluc 10
    issue(3, 0, 0, 0, 0, -1);          // STORE, ready at once
    issue(10, 0, 0, 1, 0, -1);         // IF_P all false
    issue(11, 0, 1, 0, 0, -1);         // ELSE_P all true
    issue(13, 0, 0, 0, 0, -1);         // ENDIF back to depth 0
    issue(12, 0, 0, 0, 0, -1);         // WHILE_P branch back, no stack op
    issue(0, 0, 0, 0, TMO, -1);        // ready exactly at the limit
    issue(3, 0, 0, 0, 1000, -1);       // STORE timeout
    idle(3);
    do_reset();
    idle(1);
    for (int i = 0; i < 9; i++) issue(10, 0, 0, 1'($urandom), 0, -1);
    idle(2);
    do_reset();
    issue(13, 0, 0, 0, 0, -1);         // ENDIF underflow
    idle(2);
    do_reset();
    issue(11, 0, 0, 0, 0, -1);         // ELSE_P underflow
    do_reset();
    issue(0, 0, 0, 0, 1000, 2);        // reset mid LOAD wait
    idle(1);
    issue(20, 0, 0, 0, 0, -1);         // illegal opcode
    idle(2);
    do_reset();
    issue(15, 0, 0, 0, 0, -1);         // HALT, sticky
    issue(1, 0, 0, 0, 0, -1);
    idle(2);
    do_reset();
    idle(1);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (mode != 0 && r < 60) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 2)      op = 15;
        else if (r < 5) op = $urandom_range(16, 31);
        else            op = $urandom_range(0, 14);
        d  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, TMO + 2);
        ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
        issue(op, $urandom_range(0, 3), 1'($urandom), 1'($urandom), d, ra);
      end
      idle($urandom_range(0, 2));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
